// File: rtl/lc3b_mem_unit.sv
// LC-3b memory-access sequencer: effective address, LDB/STB byte lanes, LDI/STI indirection.
// Optional alignment fault reporting is enabled by defining LC3B_MEM_ALIGN_CHECK_EN.
module lc3b_mem_unit #(
    parameter bit LDB_SEXT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  opcode,
    input  logic [15:0] base,
    input  logic [5:0]  offset6,
    input  logic [15:0] sr_data,
    output logic [15:0] load_data,
    output logic        done,
    output logic        busy,
    output logic        misaligned,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PTR    = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    function automatic logic is_byte(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_STB);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR) || (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI);
    endfunction

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] ea_q, ea_d;
    logic [15:0] sr_q, sr_d;
    logic [15:0] load_data_q, load_data_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_be_q, mem_be_d;

    logic [15:0] ea_new;
    logic [3:0]  acc_op;
    logic [15:0] acc_ea, acc_sr, acc_addr, acc_wdata;
    logic [1:0]  acc_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_word;
    logic        start_fault, ptr_fault;

    assign ea_new = is_byte(opcode) ? base + {{10{offset6[5]}}, offset6}
                                    : base + {{9{offset6[5]}}, offset6, 1'b0};

`ifdef LC3B_MEM_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    assign start_fault = is_word(opcode) && ea_new[0];
    assign ptr_fault   = mem_rdata[0];
    assign misaligned  = misaligned_q;
`else
    assign start_fault = 1'b0;
    assign ptr_fault   = 1'b0;
    assign misaligned  = 1'b0;
`endif

    // Request setup is shared by IDLE->ACCESS (fresh ea) and PTR->ACCESS (pointer just returned).
    always_comb begin
        acc_op = op_q;
        acc_ea = mem_rdata;
        acc_sr = sr_q;
        if (state_q == S_IDLE) begin
            acc_op = opcode;
            acc_ea = ea_new;
            acc_sr = sr_data;
        end
        acc_addr  = is_byte(acc_op) ? acc_ea : {acc_ea[15:1], 1'b0};
        acc_wdata = is_byte(acc_op) ? {acc_sr[7:0], acc_sr[7:0]} : acc_sr;
        acc_be    = 2'b11;
        if (is_byte(acc_op) && is_store(acc_op))
            acc_be = acc_ea[0] ? 2'b10 : 2'b01;
    end

    always_comb begin
        ld_byte = ea_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
        ld_word = mem_rdata;
        if (is_byte(op_q))
            ld_word = LDB_SEXT ? {{8{ld_byte[7]}}, ld_byte} : {8'h00, ld_byte};
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ea_d          = ea_q;
        sr_d          = sr_q;
        load_data_d   = load_data_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
`ifdef LC3B_MEM_ALIGN_CHECK_EN
        misaligned_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = opcode;
                    ea_d = ea_new;
                    sr_d = sr_data;
                    if (!is_word(opcode) && !is_byte(opcode)) begin
                        state_d = S_DONE;
                    end else if (start_fault) begin
                        state_d = S_DONE;
`ifdef LC3B_MEM_ALIGN_CHECK_EN
                        misaligned_d = 1'b1;
`endif
                    end else if (is_indirect(opcode)) begin
                        state_d       = S_PTR;
                        mem_read_d    = 1'b1;
                        mem_address_d = {ea_new[15:1], 1'b0};
                        mem_be_d      = 2'b11;
                    end else begin
                        state_d       = S_ACCESS;
                        mem_read_d    = !is_store(acc_op);
                        mem_write_d   = is_store(acc_op);
                        mem_address_d = acc_addr;
                        mem_wdata_d   = acc_wdata;
                        mem_be_d      = acc_be;
                    end
                end
            end
            S_PTR: begin
                if (mem_resp) begin
                    mem_read_d = 1'b0;
                    ea_d       = mem_rdata;
                    if (ptr_fault) begin
                        state_d = S_DONE;
`ifdef LC3B_MEM_ALIGN_CHECK_EN
                        misaligned_d = 1'b1;
`endif
                    end else begin
                        state_d       = S_ACCESS;
                        mem_read_d    = !is_store(acc_op);
                        mem_write_d   = is_store(acc_op);
                        mem_address_d = acc_addr;
                        mem_wdata_d   = acc_wdata;
                        mem_be_d      = acc_be;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (is_load(op_q))
                        load_data_d = ld_word;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            ea_q          <= '0;
            sr_q          <= '0;
            load_data_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= 2'b11;
`ifdef LC3B_MEM_ALIGN_CHECK_EN
            misaligned_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            ea_q          <= ea_d;
            sr_q          <= sr_d;
            load_data_q   <= load_data_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
`ifdef LC3B_MEM_ALIGN_CHECK_EN
            misaligned_q  <= misaligned_d;
`endif
        end
    end

    assign load_data       = load_data_q;
    assign done            = (state_q == S_DONE);
    assign busy            = (state_q != S_IDLE);
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Directed bench for lc3b_mem_unit; a second instance with LDB_SEXT=0 runs in lockstep.
module tb_lc3b_mem_unit;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  opcode;
    logic [15:0] base, sr_data, mem_rdata;
    logic [5:0]  offset6;
    logic        mem_resp;

    logic [15:0] load_data, mem_address, mem_wdata;
    logic        done, busy, misaligned, mem_read, mem_write;
    logic [1:0]  mem_be;

    logic [15:0] load_data_z, mem_address_z, mem_wdata_z;
    logic        done_z, busy_z, misaligned_z, mem_read_z, mem_write_z;
    logic [1:0]  mem_be_z;

    int checks = 0, failures = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, both_hi = 0, lockstep_err = 0;

    lc3b_mem_unit #(.LDB_SEXT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .base(base),
        .offset6(offset6), .sr_data(sr_data), .load_data(load_data), .done(done),
        .busy(busy), .misaligned(misaligned), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_be), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    lc3b_mem_unit #(.LDB_SEXT(1'b0)) u_dut_zext (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .base(base),
        .offset6(offset6), .sr_data(sr_data), .load_data(load_data_z), .done(done_z),
        .busy(busy_z), .misaligned(misaligned_z), .mem_address(mem_address_z),
        .mem_wdata(mem_wdata_z), .mem_read(mem_read_z), .mem_write(mem_write_z),
        .mem_byte_enable(mem_be_z), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_resp && mem_read) rd_cnt++;
        if (mem_resp && mem_write) wr_cnt++;
        if (done) done_cnt++;
        if (mem_read && mem_write) both_hi++;
        if ({done_z, busy_z, misaligned_z, mem_read_z, mem_write_z, mem_address_z, mem_wdata_z, mem_be_z}
            !== {done, busy, misaligned, mem_read, mem_write, mem_address, mem_wdata, mem_be})
            lockstep_err++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on the first request cycle; returns on the cycle after the response (k=1).
    task automatic resp_k1(input logic [15:0] d);
        tick();
        mem_resp  = 1'b1;
        mem_rdata = d;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 4'h0; base = 16'h0; offset6 = 6'h0;
        sr_data = 16'h0; mem_rdata = 16'h0; mem_resp = 1'b0;
        tick();
        tick();
        chk("rst_load_data", load_data, 16'h0000);
        chk("rst_done", done, 16'h0);
        chk("rst_busy", busy, 16'h0);
        chk("rst_misaligned", misaligned, 16'h0);
        chk("rst_mem_read", mem_read, 16'h0);
        chk("rst_mem_write", mem_write, 16'h0);
        chk("rst_address", mem_address, 16'h0000);
        chk("rst_wdata", mem_wdata, 16'h0000);
        chk("rst_be", mem_be, 16'h3);
        rst = 1'b0;
        tick();

        // LDR 0x3000 + (-1 << 1)
        start = 1'b1; opcode = 4'b0110; base = 16'h3000; offset6 = 6'h3F;
        tick();
        start = 1'b0;
        chk("ldr_busy", busy, 16'h1);
        chk("ldr_read", mem_read, 16'h1);
        chk("ldr_nowrite", mem_write, 16'h0);
        chk("ldr_addr", mem_address, 16'h2FFE);
        chk("ldr_be", mem_be, 16'h3);
        tick();
        chk("ldr_addr_hold", mem_address, 16'h2FFE);
        chk("ldr_read_hold", mem_read, 16'h1);
        chk("ldr_not_done_early", done, 16'h0);
        mem_resp = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_resp = 1'b0; mem_rdata = 16'h0;
        chk("ldr_done_c3", done, 16'h1);
        chk("ldr_data", load_data, 16'hBEEF);
        chk("ldr_data_z", load_data_z, 16'hBEEF);
        chk("ldr_read_drop", mem_read, 16'h0);
        tick();
        chk("ldr_done_one_cycle", done, 16'h0);
        chk("ldr_idle", busy, 16'h0);
        chk("ldr_reads", rd_cnt, 16'd1);

        // STB odd byte
        start = 1'b1; opcode = 4'b0011; base = 16'h1001; offset6 = 6'h00; sr_data = 16'h12A5;
        tick();
        start = 1'b0;
        chk("stb_write", mem_write, 16'h1);
        chk("stb_noread", mem_read, 16'h0);
        chk("stb_addr", mem_address, 16'h1001);
        chk("stb_wdata", mem_wdata, 16'hA5A5);
        chk("stb_be", mem_be, 16'h2);
        resp_k1(16'h0000);
        chk("stb_done", done, 16'h1);
        chk("stb_load_kept", load_data, 16'hBEEF);
        chk("stb_write_drop", mem_write, 16'h0);
        tick();
        chk("stb_writes", wr_cnt, 16'd1);

        // LDB odd byte, both extension modes
        start = 1'b1; opcode = 4'b0010; base = 16'h1001; offset6 = 6'h00;
        tick();
        start = 1'b0;
        chk("ldb_odd_addr", mem_address, 16'h1001);
        chk("ldb_odd_be", mem_be, 16'h3);
        resp_k1(16'hA5FF);
        chk("ldb_odd_done", done, 16'h1);
        chk("ldb_odd_sext", load_data, 16'hFFA5);
        chk("ldb_odd_zext", load_data_z, 16'h00A5);
        tick();

        // LDB even byte via negative offset
        start = 1'b1; opcode = 4'b0010; base = 16'h1002; offset6 = 6'h3E;
        tick();
        start = 1'b0;
        chk("ldb_even_addr", mem_address, 16'h1000);
        resp_k1(16'h7F80);
        chk("ldb_even_sext", load_data, 16'hFF80);
        chk("ldb_even_zext", load_data_z, 16'h0080);
        tick();

        // LDI: pointer read then data read
        start = 1'b1; opcode = 4'b1010; base = 16'h4000; offset6 = 6'h01;
        tick();
        start = 1'b0;
        chk("ldi_ptr_read", mem_read, 16'h1);
        chk("ldi_ptr_addr", mem_address, 16'h4002);
        tick();
        mem_resp = 1'b1; mem_rdata = 16'h5000;
        tick();
        mem_resp = 1'b0; mem_rdata = 16'h0;
        chk("ldi_data_read", mem_read, 16'h1);
        chk("ldi_data_addr", mem_address, 16'h5000);
        chk("ldi_not_done", done, 16'h0);
        resp_k1(16'h0042);
        chk("ldi_done_c5", done, 16'h1);
        chk("ldi_data", load_data, 16'h0042);
        tick();
        chk("ldi_done_one_cycle", done, 16'h0);
        chk("ldi_reads", rd_cnt, 16'd5);
        chk("ldi_done_count", done_cnt, 16'd5);

        // Address wrap; start while busy and start during DONE are dropped
        start = 1'b1; opcode = 4'b0110; base = 16'hFFFE; offset6 = 6'h02;
        tick();
        chk("wrap_addr", mem_address, 16'h0002);
        opcode = 4'b0111; base = 16'h0000;
        tick();
        start = 1'b0;
        mem_resp = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_resp = 1'b0; mem_rdata = 16'h0;
        chk("wrap_done", done, 16'h1);
        chk("wrap_data", load_data, 16'h1234);
        start = 1'b1; opcode = 4'b0110;
        tick();
        start = 1'b0;
        chk("done_start_ignored", busy, 16'h0);
        chk("done_start_noreq", mem_read, 16'h0);
        tick();
        tick();
        chk("busy_start_no_write", wr_cnt, 16'd1);
        chk("busy_start_no_read", rd_cnt, 16'd6);

        // Non-memory opcode: straight to DONE
        start = 1'b1; opcode = 4'b0001;
        tick();
        start = 1'b0;
        chk("nonmem_done", done, 16'h1);
        chk("nonmem_busy", busy, 16'h1);
        chk("nonmem_noreq", {mem_read, mem_write}, 16'h0);
        tick();
        chk("nonmem_done_count", done_cnt, 16'd7);

        // Async reset mid-request
        start = 1'b1; opcode = 4'b0110; base = 16'h0000; offset6 = 6'h00;
        tick();
        start = 1'b0;
        chk("rstmid_read_before", mem_read, 16'h1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_read", mem_read, 16'h0);
        chk("rstmid_busy", busy, 16'h0);
        chk("rstmid_load_data", load_data, 16'h0000);
        chk("rstmid_be", mem_be, 16'h3);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_resp = 1'b1; mem_rdata = 16'hFFFF;
        tick();
        mem_resp = 1'b0; mem_rdata = 16'h0;
        chk("rstmid_no_done", done, 16'h0);
        tick();
        chk("rstmid_done_count", done_cnt, 16'd7);

        // Odd word address
        start = 1'b1; opcode = 4'b0111; base = 16'h2001; offset6 = 6'h00; sr_data = 16'h5A5A;
        tick();
        start = 1'b0;
`ifdef LC3B_MEM_ALIGN_CHECK_EN
        chk("align_no_write", mem_write, 16'h0);
        chk("align_done", done, 16'h1);
        chk("align_flag", misaligned, 16'h1);
        tick();
        chk("align_flag_clear", misaligned, 16'h0);
        chk("align_writes", wr_cnt, 16'd1);
`else
        chk("noalign_write", mem_write, 16'h1);
        chk("noalign_addr", mem_address, 16'h2000);
        chk("noalign_wdata", mem_wdata, 16'h5A5A);
        chk("noalign_be", mem_be, 16'h3);
        resp_k1(16'h0000);
        chk("noalign_done", done, 16'h1);
        chk("noalign_flag", misaligned, 16'h0);
        tick();
        chk("noalign_writes", wr_cnt, 16'd2);
`endif

        chk("never_both_requests", both_hi, 16'd0);
        chk("zext_lockstep", lockstep_err, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_unit.md
Name: lc3b_mem_unit

Overview:
- Memory-access sequencer for the LC-3b datapath.
- Accepts a decoded memory instruction (lc3b_opcode, base register value, offset6, store data) and computes the effective address.
- Runs one or two request/response transactions on the memory port and returns load data plus a one-cycle done pulse to the control FSM.
- Handles byte lanes for LDB/STB and the two-access indirection of LDI/STI.

Parameters:
LDB_SEXT, 1, 1 = LDB result sign-extended from the selected byte; 0 = zero-extended.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request pulse; sampled only in IDLE
opcode  in  4  lc3b_opcode of the instruction
base  in  16  BaseR value (lc3b_word)
offset6  in  6  lc3b_offset6 from the instruction
sr_data  in  16  store data (lc3b_word)
load_data  out  16  load result (lc3b_word); valid when done=1
done  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE
misaligned  out  1  alignment fault flag; see Optional Feature
mem_address  out  16  memory address
mem_wdata  out  16  memory write data
mem_read  out  1  read request; held until mem_resp
mem_write  out  1  write request; held until mem_resp
mem_byte_enable  out  2  lc3b_mem_wmask; bit1 = high byte
mem_rdata  in  16  memory read data; valid with mem_resp
mem_resp  in  1  one-cycle transaction acknowledge

Behaviour:
- Reset (async, any state): state=IDLE. load_data=0, done=0, busy=0, misaligned=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=2'b11. Any outstanding request is dropped immediately, and a mem_resp arriving afterwards is ignored.
- Memory opcodes: op_ldr, op_str, op_ldb, op_stb, op_ldi, op_sti.
- Effective address (16-bit, wraps modulo 2^16):
  - ldr/str/ldi/sti: ea = base + (SEXT(offset6) << 1).
  - ldb/stb: ea = base + SEXT(offset6).
- On start in IDLE, latch opcode, ea and sr_data.
- States:
  - IDLE -> PTR on start with op_ldi/op_sti.
  - IDLE -> ACCESS on start with any other memory opcode.
  - IDLE -> DONE on start with a non-memory opcode; no memory traffic.
  - PTR: mem_read=1, mem_address=ea with bit0 forced 0, mem_byte_enable=2'b11. On mem_resp, latch mem_rdata as the new ea -> ACCESS.
  - ACCESS, loads (ldr/ldi/ldb): mem_read=1, mem_byte_enable=2'b11. On mem_resp, capture load_data -> DONE.
  - ACCESS, stores (str/sti/stb): mem_write=1. On mem_resp -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Word accesses: mem_address = {ea[15:1],0}, mem_byte_enable=2'b11, mem_wdata=sr_data, load_data=mem_rdata.
- Byte accesses:
  - mem_address=ea.
  - STB: mem_wdata={sr_data[7:0],sr_data[7:0]}, mem_byte_enable = ea[0] ? 2'b10 : 2'b01.
  - LDB: byte = ea[0] ? mem_rdata[15:8] : mem_rdata[7:0], extended per LDB_SEXT.
- Request rules:
  - mem_read/mem_write are never high together.
  - Requests are registered and asserted starting the cycle after entering the state.
  - mem_address and mem_wdata are held stable while a request is high.
  - Both requests drop the cycle after mem_resp.
- Latency with mem_resp k cycles after request assertion (k>=1): single access, done at cycle 2+k after start; LDI/STI add k+1.
- start while busy is ignored, with no queuing. start in the DONE cycle is also ignored.
- mem_resp in IDLE or DONE is ignored.
- load_data holds its value until the next completed load; stores do not change it.

Optional Feature:
- Macro LC3B_MEM_ALIGN_CHECK_EN.
- Defined: a word access (ACCESS, or the LDI/STI pointer read) with ea[0]=1 issues no transaction. The unit goes directly to DONE with misaligned=1 during the done cycle, and load_data is unchanged.
- An odd pointer value returned by PTR faults the same way.
- Not defined: misaligned is tied 0, and bit0 is silently forced 0 as above.

Test Plan:
- LDR base=0x3000, offset6=6'h3F, mem returns 0xBEEF after k=1 -> one read at 0x2FFE, byte_enable 11; done at cycle 3; load_data=0xBEEF.
- STB base=0x1001, offset6=0, sr_data=0x12A5 -> write at 0x1001, wdata=0xA5A5, byte_enable 10; LDB at the same address with rdata=0xA5FF -> load_data=0xFFA5 (LDB_SEXT=1), 0x00A5 (LDB_SEXT=0).
- LDI base=0x4000, offset6=1 -> read 0x4002 returns 0x5000, then read 0x5000 returns 0x0042 -> load_data=0x0042, exactly two reads, done once.
- Wrap and busy: LDR base=0xFFFE, offset6=2 -> address 0x0002. A start pulse mid-access produces no second transaction.
- Reset asserted while mem_read=1 -> mem_read=0 and busy=0 asynchronously; a later mem_resp produces no done.
- LC3B_MEM_ALIGN_CHECK_EN defined: STR ea=0x2001 -> no mem_write, done=1 with misaligned=1. Macro undefined: write at 0x2000.
